// File: rtl/rmii_tx_serializer.sv
// rmii_tx_serializer
//   MII-to-RMII transmit stage. It generates the MII TX clock from the 50 MHz
//   RMII reference clock, captures one MII nibble per MII clock period and
//   shifts it out as two RMII dibits (low dibit first). Frame and error
//   bookkeeping is exposed for software through the status path.
//
// Ports
//   ref_clk      50 MHz RMII reference clock (sole clock)
//   rst          synchronous active-high reset
//   speed_100    1 = 100 Mb/s, 0 = 10 Mb/s; only taken between frames
//   mii_tx_clk   generated MII TX clock (registered square wave)
//   mii_txd      MAC transmit nibble
//   mii_tx_en    MAC transmit enable
//   mii_tx_er    MAC transmit error
//   rmii_txd     RMII transmit dibit (registered)
//   rmii_tx_en   RMII transmit enable (registered)
//   stat_clr     clears frame_cnt and the sticky error flags (wins over updates)
//   frame_cnt    number of started frames, wraps
//   err_txer     sticky: tx_er seen together with tx_en
//   err_odd      sticky: a frame ended after an odd number of nibbles
module rmii_tx_serializer #(
  parameter int DIV10 = 10,
  parameter int CNT_W = 16
) (
  input  logic             ref_clk,
  input  logic             rst,
  input  logic             speed_100,
  output logic             mii_tx_clk,
  input  logic [3:0]       mii_txd,
  input  logic             mii_tx_en,
  input  logic             mii_tx_er,
  output logic [1:0]       rmii_txd,
  output logic             rmii_tx_en,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_txer,
  output logic             err_odd
);

  localparam int DW = (DIV10 > 2) ? $clog2(DIV10) : 1;

  logic [DW-1:0]    r_div;
  logic             r_ph;
  logic             r_spd;
  logic [3:0]       r_nib;
  logic             r_en_q;
  logic             r_er_q;
  logic             r_par;
  logic [1:0]       r_txd;
  logic             r_txen;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_txer;
  logic             r_err_odd;

  logic [DW-1:0]    w_dmax;
  logic             w_wrap;
  logic             w_cap;
  logic             w_out;
  logic             w_start;
  logic             w_end;
  logic [3:0]       w_nib;

  // Wrap uses >= so a speed switch taken mid-count (10M -> 100M) still
  // returns the divider to zero on the next edge instead of running away.
  assign w_dmax  = r_spd ? '0 : DW'(DIV10 - 1);
  assign w_wrap  = (r_div >= w_dmax);
  assign w_cap   = (r_div == '0) && !r_ph;
  // Output dibits change on every divider zero: phase 1 emits the low dibit
  // of the freshly captured nibble, phase 0 the high dibit.
  assign w_out   = (r_div == '0);
  assign w_start = w_cap &&  mii_tx_en && !r_en_q;
  assign w_end   = w_cap && !mii_tx_en &&  r_en_q;
  // An errored nibble is replaced by a 0101 pattern on the wire.
  assign w_nib   = r_er_q ? 4'b0101 : r_nib;

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      r_div      <= '0;
      r_ph       <= 1'b0;
      r_spd      <= 1'b1;
      r_nib      <= '0;
      r_en_q     <= 1'b0;
      r_er_q     <= 1'b0;
      r_par      <= 1'b0;
      r_txd      <= 2'b00;
      r_txen     <= 1'b0;
      r_cnt      <= '0;
      r_err_txer <= 1'b0;
      r_err_odd  <= 1'b0;
    end else begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      if (w_wrap) r_ph <= ~r_ph;

      if (w_cap) begin
        r_nib  <= mii_txd;
        r_en_q <= mii_tx_en;
        r_er_q <= mii_tx_en && mii_tx_er;
        // Speed only changes with two idle nibbles in a row, so a frame
        // never straddles a rate change.
        if (!mii_tx_en && !r_en_q) r_spd <= speed_100;
        if (mii_tx_en) r_par <= w_start ? 1'b1 : ~r_par;
      end

      if (w_out) begin
        r_txd  <= r_en_q ? (r_ph ? w_nib[1:0] : w_nib[3:2]) : 2'b00;
        r_txen <= r_en_q;
      end

      if (stat_clr) begin
        r_cnt      <= '0;
        r_err_txer <= 1'b0;
        r_err_odd  <= 1'b0;
      end else begin
        if (w_start) r_cnt <= r_cnt + 1'b1;
        if (w_cap && mii_tx_en && mii_tx_er) r_err_txer <= 1'b1;
        if (w_end && r_par) r_err_odd <= 1'b1;
      end
    end
  end

  assign mii_tx_clk = r_ph;
  assign rmii_txd   = r_txd;
  assign rmii_tx_en = r_txen;
  assign frame_cnt  = r_cnt;
  assign err_txer   = r_err_txer;
  assign err_odd    = r_err_odd;

endmodule
